// File: rtl/spi_speed_slave_if.sv
// SPI pin bundle between the host and the wheel-speed readout slave.
interface spi_speed_slave_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport slave  (input spi_sclk, input spi_cs_n, input spi_mosi, output spi_miso);
  modport master (output spi_sclk, output spi_cs_n, output spi_mosi, input spi_miso);
endinterface

// File: rtl/spi_speed_slave.sv
// SPI mode-0 slave returning coherent snapshots of the left/right wheel counts.
// Optional frame counter at address 0x03 when SPI_FRAME_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for chip-select fall, MISO low
// ADDR  | shifting in the 8-bit address
// DATA  | shifting out 16 data bits on SCLK falls
// DONE  | frame complete, SCLK ignored until CS rises
module spi_speed_slave #(
  parameter logic [15:0] ID_VALUE    = 16'hA55A,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       count_left,
  input  logic [15:0]       count_right,
  spi_speed_slave_if.slave  spi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Top bit of the sclk/cs chains is the edge-detect history flop.
  logic [SYNC_STAGES:0]   sclkSync;
  logic [SYNC_STAGES:0]   csSync;
  logic [SYNC_STAGES-1:0] mosiSync;

  logic [1:0]  state;
  logic [4:0]  bitCnt;
  logic [6:0]  addr;
  logic [15:0] shiftReg;
  logic [15:0] snapLeft;
  logic [15:0] snapRight;
  logic        misoReg;
`ifdef SPI_FRAME_CNT_EN
  logic [15:0] frameCnt;
`endif

  logic        sclkRise;
  logic        sclkFall;
  logic        csFall;
  logic        csHigh;
  logic        mosiS;
  logic [7:0]  addrNext;
  logic [15:0] mapData;

  assign sclkRise = sclkSync[SYNC_STAGES-1] & ~sclkSync[SYNC_STAGES];
  assign sclkFall = ~sclkSync[SYNC_STAGES-1] & sclkSync[SYNC_STAGES];
  assign csFall   = ~csSync[SYNC_STAGES-1] & csSync[SYNC_STAGES];
  assign csHigh   = csSync[SYNC_STAGES-1];
  assign mosiS    = mosiSync[SYNC_STAGES-1];
  assign addrNext = {addr, mosiS};
  assign spi.spi_miso = misoReg;

  always_comb begin
    mapData = 16'h0000;
    case (addrNext)
      8'h00: mapData = snapLeft;
      8'h01: mapData = snapRight;
      8'h02: mapData = ID_VALUE;
`ifdef SPI_FRAME_CNT_EN
      8'h03: mapData = frameCnt;
`endif
      default: mapData = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclkSync <= '0;
      csSync   <= '1;
      mosiSync <= '0;
    end else begin
      sclkSync <= {sclkSync[SYNC_STAGES-1:0], spi.spi_sclk};
      csSync   <= {csSync[SYNC_STAGES-1:0], spi.spi_cs_n};
      mosiSync <= {mosiSync[SYNC_STAGES-2:0], spi.spi_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      addr      <= '0;
      shiftReg  <= '0;
      snapLeft  <= '0;
      snapRight <= '0;
      misoReg   <= 1'b0;
`ifdef SPI_FRAME_CNT_EN
      frameCnt  <= '0;
`endif
    end else if (csHigh) begin
      // CS high wins over any SCLK edge in the same cycle.
      state   <= IDLE;
      misoReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          misoReg <= 1'b0;
          if (csFall) begin
            snapLeft  <= count_left;
            snapRight <= count_right;
            bitCnt    <= '0;
            state     <= ADDR;
`ifdef SPI_FRAME_CNT_EN
            frameCnt  <= frameCnt + 16'd1;
`endif
          end
        end
        ADDR: begin
          misoReg <= 1'b0;
          if (sclkRise) begin
            addr   <= addrNext[6:0];
            bitCnt <= bitCnt + 5'd1;
            if (bitCnt == 5'd7) begin
              shiftReg <= mapData;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (sclkFall) begin
            misoReg  <= shiftReg[15];
            shiftReg <= {shiftReg[14:0], 1'b0};
          end
          if (sclkRise) begin
            bitCnt <= bitCnt + 5'd1;
            if (bitCnt == 5'd23) state <= DONE;
          end
        end
        default: begin
          misoReg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_speed_slave.sv
// Directed bench for spi_speed_slave: host-side SPI frames with hand-computed results.
module tb_spi_speed_slave;
  localparam int HALF = 10;

  logic        clk;
  logic        reset;
  logic [15:0] count_left;
  logic [15:0] count_right;
  int          checks;
  int          failures;

  spi_speed_slave_if spiBus ();

  spi_speed_slave dut (
    .clk         (clk),
    .reset       (reset),
    .count_left  (count_left),
    .count_right (count_right),
    .spi         (spiBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitClk(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // rx collects MISO as sampled just before each SCLK rise, MSB first.
  task automatic spiFrame(input logic [7:0] a, input int nbits, input int chgBit,
                          input logic [15:0] chgVal, output logic [31:0] rx);
    logic [7:0] aBits;
    aBits = a;
    rx = '0;
    spiBus.spi_cs_n = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == chgBit) count_right = chgVal;
      spiBus.spi_mosi = (i < 8) ? aBits[7-i] : 1'b0;
      waitClk(HALF);
      rx = {rx[30:0], spiBus.spi_miso};
      spiBus.spi_sclk = 1'b1;
      waitClk(HALF);
      spiBus.spi_sclk = 1'b0;
    end
    waitClk(HALF);
    spiBus.spi_cs_n = 1'b1;
    spiBus.spi_mosi = 1'b0;
    waitClk(HALF);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    spiBus.spi_cs_n = 1'b1;
    spiBus.spi_sclk = 1'b0;
    spiBus.spi_mosi = 1'b0;
    waitClk(3);
    reset = 1'b0;
    waitClk(2);
  endtask

  task automatic test_reset();
    logic [31:0] rx;
    applyReset();
    checks++;
    if (spiBus.spi_miso !== 1'b0) begin
      failures++; $display("FAIL reset_miso got=%b want=0", spiBus.spi_miso);
    end
    checks++;
    if (dut.state !== 2'd0) begin
      failures++; $display("FAIL reset_state got=%0d want=0", dut.state);
    end
    spiFrame(8'h02, 24, -1, 16'h0, rx);
    checks++;
    if (rx[15:0] !== 16'hA55A) begin
      failures++; $display("FAIL id_read got=%h want=a55a", rx[15:0]);
    end
  endtask

  task automatic test_left_read();
    logic [31:0] rx;
    count_left = 16'h1234;
    spiFrame(8'h00, 24, -1, 16'h0, rx);
    checks++;
    if (rx[15:0] !== 16'h1234) begin
      failures++; $display("FAIL left_data got=%h want=1234", rx[15:0]);
    end
    checks++;
    if (rx[23:16] !== 8'h00) begin
      failures++; $display("FAIL left_addr_phase got=%h want=00", rx[23:16]);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] rx;
    count_right = 16'hFFF6;
    spiFrame(8'h01, 24, 3, 16'h0003, rx);
    checks++;
    if (rx[15:0] !== 16'hFFF6) begin
      failures++; $display("FAIL snapshot_hold got=%h want=fff6", rx[15:0]);
    end
    spiFrame(8'h01, 24, -1, 16'h0, rx);
    checks++;
    if (rx[15:0] !== 16'h0003) begin
      failures++; $display("FAIL snapshot_next got=%h want=0003", rx[15:0]);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rx;
    spiFrame(8'h7F, 24, -1, 16'h0, rx);
    checks++;
    if (rx[15:0] !== 16'h0000) begin
      failures++; $display("FAIL unmapped_7f got=%h want=0000", rx[15:0]);
    end
`ifndef SPI_FRAME_CNT_EN
    spiFrame(8'h03, 24, -1, 16'h0, rx);
    checks++;
    if (rx[15:0] !== 16'h0000) begin
      failures++; $display("FAIL addr03_disabled got=%h want=0000", rx[15:0]);
    end
`endif
  endtask

  task automatic test_abort();
    logic [31:0] rx;
    spiFrame(8'h02, 5, -1, 16'h0, rx);
    checks++;
    if (spiBus.spi_miso !== 1'b0) begin
      failures++; $display("FAIL abort_miso got=%b want=0", spiBus.spi_miso);
    end
    checks++;
    if (dut.state !== 2'd0) begin
      failures++; $display("FAIL abort_state got=%0d want=0", dut.state);
    end
    count_left = 16'h0042;
    spiFrame(8'h00, 24, -1, 16'h0, rx);
    checks++;
    if (rx[15:0] !== 16'h0042) begin
      failures++; $display("FAIL abort_next got=%h want=0042", rx[15:0]);
    end
  endtask

  task automatic test_frame_length();
    logic [31:0] rx;
    count_left = 16'h8001;
    spiFrame(8'h00, 32, -1, 16'h0, rx);
    checks++;
    if (rx[23:8] !== 16'h8001) begin
      failures++; $display("FAIL long_data got=%h want=8001", rx[23:8]);
    end
    checks++;
    if (rx[7:0] !== 8'h00) begin
      failures++; $display("FAIL long_extra got=%h want=00", rx[7:0]);
    end
    spiFrame(8'h02, 12, -1, 16'h0, rx);
    checks++;
    if (rx[3:0] !== 4'hA) begin
      failures++; $display("FAIL short_nibble got=%h want=a", rx[3:0]);
    end
    count_right = 16'h5AA5;
    spiFrame(8'h01, 24, -1, 16'h0, rx);
    checks++;
    if (rx[15:0] !== 16'h5AA5) begin
      failures++; $display("FAIL after_short got=%h want=5aa5", rx[15:0]);
    end
  endtask

`ifdef SPI_FRAME_CNT_EN
  task automatic test_frame_cnt();
    logic [31:0] rx;
    logic [15:0] want [3];
    want[0] = 16'h0001; want[1] = 16'h0002; want[2] = 16'h0003;
    applyReset();
    for (int i = 0; i < 3; i++) begin
      spiFrame(8'h03, 24, -1, 16'h0, rx);
      checks++;
      if (rx[15:0] !== want[i]) begin
        failures++; $display("FAIL frame_cnt_%0d got=%h want=%h", i, rx[15:0], want[i]);
      end
    end
    force dut.frameCnt = 16'hFFFF;
    waitClk(2);
    release dut.frameCnt;
    waitClk(2);
    spiFrame(8'h03, 24, -1, 16'h0, rx);
    checks++;
    if (rx[15:0] !== 16'h0000) begin
      failures++; $display("FAIL frame_cnt_wrap got=%h want=0000", rx[15:0]);
    end
  endtask
`endif

  initial begin
    checks      = 0;
    failures    = 0;
    count_left  = 16'h0000;
    count_right = 16'h0000;
    test_reset();
    test_left_read();
    test_snapshot();
    test_unmapped();
    test_abort();
    test_frame_length();
`ifdef SPI_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
